// File: rtl/branch_resolve_unit.sv
// rtl/branch_resolve_unit.sv - in-order branch resolution, BHT write-back and mispredict flush
//
// Holds each fetched branch's {pc, ctr, target} in an in-order FIFO until
// execute resolves the oldest one. On resolve, the unit writes the updated
// 2-bit counter back to the BHT. On a mispredict it also pulses flush/redirect
// and squashes every younger in-flight entry.
//
// Ports:
//   clk, rst_n          clock (rising edge) and asynchronous active-low reset
//   pred_valid/pc/ctr/  fetch-side push of a predicted branch;
//   pred_target         pred_ready = FIFO not full
//   res_valid/taken/    execute-side resolve of the oldest in-flight branch
//   res_target
//   flush, redirect_pc  one-cycle mispredict pulse and the correct next PC
//   upd_valid/idx/ctr   one-cycle BHT counter write strobe
//   inflight            current FIFO occupancy (0..DEPTH)
//   branch_cnt,         saturating counts of resolved branches and mispredicts
//   mispred_cnt
//   err_underflow       sticky: a resolve arrived while the FIFO was empty
module branch_resolve_unit #(
  parameter int N     = 32,
  parameter int DEPTH = 4,
  parameter int IDX   = 4,
  localparam int CW   = $clog2(DEPTH) + 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           pred_valid,
  input  logic [N-1:0]   pred_pc,
  input  logic [1:0]     pred_ctr,
  input  logic [N-1:0]   pred_target,
  output logic           pred_ready,
  input  logic           res_valid,
  input  logic           res_taken,
  input  logic [N-1:0]   res_target,
  output logic           flush,
  output logic [N-1:0]   redirect_pc,
  output logic           upd_valid,
  output logic [IDX-1:0] upd_idx,
  output logic [1:0]     upd_ctr,
  output logic [CW-1:0]  inflight,
  output logic [15:0]    branch_cnt,
  output logic [15:0]    mispred_cnt,
  output logic           err_underflow
);

  localparam int PW = $clog2(DEPTH);

  // Entry storage. Contents need no reset: occupancy and pointers decide validity.
  logic [N-1:0]  pc_mem  [DEPTH];
  logic [1:0]    ctr_mem [DEPTH];
  logic [N-1:0]  tgt_mem [DEPTH];

  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;

  logic [N-1:0]  head_pc;
  logic [1:0]    head_ctr;
  logic [N-1:0]  head_tgt;
  logic          head_pred_taken;
  logic          do_pop;
  logic          mispred;
  logic          squash;
  logic          do_push;
  logic [1:0]    new_ctr;

  function automatic logic [1:0] sat_inc(input logic [1:0] c);
    return (c == 2'b11) ? c : c + 2'b01;
  endfunction

  function automatic logic [1:0] sat_dec(input logic [1:0] c);
    return (c == 2'b00) ? c : c - 2'b01;
  endfunction

  assign pred_ready = (inflight < CW'(DEPTH));

  assign head_pc         = pc_mem[rd_ptr];
  assign head_ctr        = ctr_mem[rd_ptr];
  assign head_tgt        = tgt_mem[rd_ptr];
  assign head_pred_taken = head_ctr[1];

  assign do_pop = res_valid && (inflight != '0);

  // A taken branch predicted taken still mispredicts if it went somewhere else.
  assign mispred = (res_taken != head_pred_taken) ||
                   (res_taken && head_pred_taken && (res_target != head_tgt));

  assign squash = do_pop && mispred;

  // No bypass: a push needs registered space, and anything pushed alongside
  // a mispredict resolve is wrong-path and is dropped.
  assign do_push = pred_valid && pred_ready && !squash;

  assign new_ctr = res_taken ? sat_inc(head_ctr) : sat_dec(head_ctr);

  always_ff @(posedge clk) begin
    if (do_push) begin
      pc_mem[wr_ptr]  <= pred_pc;
      ctr_mem[wr_ptr] <= pred_ctr;
      tgt_mem[wr_ptr] <= pred_target;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr        <= '0;
      wr_ptr        <= '0;
      inflight      <= '0;
      flush         <= 1'b0;
      redirect_pc   <= '0;
      upd_valid     <= 1'b0;
      upd_idx       <= '0;
      upd_ctr       <= 2'b00;
      branch_cnt    <= '0;
      mispred_cnt   <= '0;
      err_underflow <= 1'b0;
    end else begin
      // Occupancy and pointers.
      if (squash) begin
        rd_ptr   <= '0;
        wr_ptr   <= '0;
        inflight <= '0;
      end else begin
        if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
        if (do_push) wr_ptr <= wr_ptr + PW'(1);
        if (do_push && !do_pop)      inflight <= inflight + CW'(1);
        else if (do_pop && !do_push) inflight <= inflight - CW'(1);
      end

      // One-cycle result pulses; everything returns to 0 when idle.
      upd_valid   <= do_pop;
      upd_idx     <= do_pop ? head_pc[IDX-1:0] : '0;
      upd_ctr     <= do_pop ? new_ctr : 2'b00;
      flush       <= squash;
      redirect_pc <= squash ? (res_taken ? res_target : head_pc + N'(4)) : '0;

      if (do_pop && (branch_cnt != 16'hFFFF))
        branch_cnt <= branch_cnt + 16'd1;
      if (squash && (mispred_cnt != 16'hFFFF))
        mispred_cnt <= mispred_cnt + 16'd1;

      if (res_valid && (inflight == '0))
        err_underflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// tb/tb_branch_resolve_unit.sv - self-checking bench for branch_resolve_unit
module tb_branch_resolve_unit;

  localparam int N     = 32;
  localparam int DEPTH = 4;
  localparam int IDX   = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic           clk;
  logic           rst_n;
  logic           pred_valid;
  logic [N-1:0]   pred_pc;
  logic [1:0]     pred_ctr;
  logic [N-1:0]   pred_target;
  logic           pred_ready;
  logic           res_valid;
  logic           res_taken;
  logic [N-1:0]   res_target;
  logic           flush;
  logic [N-1:0]   redirect_pc;
  logic           upd_valid;
  logic [IDX-1:0] upd_idx;
  logic [1:0]     upd_ctr;
  logic [CW-1:0]  inflight;
  logic [15:0]    branch_cnt;
  logic [15:0]    mispred_cnt;
  logic           err_underflow;

  branch_resolve_unit #(.N(N), .DEPTH(DEPTH), .IDX(IDX)) dut (
    .clk(clk), .rst_n(rst_n),
    .pred_valid(pred_valid), .pred_pc(pred_pc), .pred_ctr(pred_ctr),
    .pred_target(pred_target), .pred_ready(pred_ready),
    .res_valid(res_valid), .res_taken(res_taken), .res_target(res_target),
    .flush(flush), .redirect_pc(redirect_pc),
    .upd_valid(upd_valid), .upd_idx(upd_idx), .upd_ctr(upd_ctr),
    .inflight(inflight), .branch_cnt(branch_cnt), .mispred_cnt(mispred_cnt),
    .err_underflow(err_underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      if (n_bad <= 60)
        $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    logic [31:0] pc;
    logic [1:0]  ctr;
    logic [31:0] tgt;
  } ent_t;

  ent_t q[$];
  int   e_upd_valid, e_upd_idx, e_upd_ctr, e_flush;
  int   e_branch, e_mis, e_err;
  logic [31:0] e_redirect;

  always @(posedge clk or negedge rst_n) begin : model
    int   sz;
    bit   mis;
    bit   ptaken;
    ent_t h;
    ent_t nw;
    if (!rst_n) begin
      q.delete();
      e_upd_valid = 0; e_upd_idx = 0; e_upd_ctr = 0; e_flush = 0;
      e_redirect = 0; e_branch = 0; e_mis = 0; e_err = 0;
    end else begin
      sz  = q.size();
      mis = 0;
      e_upd_valid = 0; e_upd_idx = 0; e_upd_ctr = 0; e_flush = 0; e_redirect = 0;
      if (res_valid) begin
        if (sz == 0) begin
          e_err = 1;
        end else begin
          h = q.pop_front();
          ptaken = (h.ctr >= 2);
          e_upd_valid = 1;
          e_upd_idx   = int'(h.pc) % 16;
          if (res_taken) e_upd_ctr = (h.ctr == 3) ? 3 : int'(h.ctr) + 1;
          else           e_upd_ctr = (h.ctr == 0) ? 0 : int'(h.ctr) - 1;
          mis = (res_taken != ptaken) || (res_taken && ptaken && res_target != h.tgt);
          if (e_branch < 65535) e_branch++;
          if (mis) begin
            e_flush    = 1;
            e_redirect = res_taken ? res_target : h.pc + 32'd4;
            if (e_mis < 65535) e_mis++;
            q.delete();
          end
        end
      end
      if (pred_valid && sz < DEPTH && !mis) begin
        nw.pc = pred_pc; nw.ctr = pred_ctr; nw.tgt = pred_target;
        q.push_back(nw);
      end
    end
  end

  // Compare process: outputs are all meaningful every cycle out of reset.
  always @(negedge clk) begin
    if (rst_n) begin
      check("pred_ready",    32'(pred_ready),    (q.size() < DEPTH) ? 1 : 0);
      check("inflight",      32'(inflight),      q.size());
      check("upd_valid",     32'(upd_valid),     e_upd_valid);
      check("upd_idx",       32'(upd_idx),       e_upd_idx);
      check("upd_ctr",       32'(upd_ctr),       e_upd_ctr);
      check("flush",         32'(flush),         e_flush);
      check("redirect_pc",   redirect_pc,        e_redirect);
      check("branch_cnt",    32'(branch_cnt),    e_branch);
      check("mispred_cnt",   32'(mispred_cnt),   e_mis);
      check("err_underflow", 32'(err_underflow), e_err);
    end
  end

  // ---------------- stimulus ----------------
  task automatic step(input bit pv, input logic [31:0] ppc, input logic [1:0] pc2,
                      input logic [31:0] ptgt, input bit rv, input bit rt,
                      input logic [31:0] rtgt);
    pred_valid = pv; pred_pc = ppc; pred_ctr = pc2; pred_target = ptgt;
    res_valid = rv; res_taken = rt; res_target = rtgt;
    @(posedge clk);
    #1;
    pred_valid = 1'b0; res_valid = 1'b0;
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    rst_n = 1'b0;
    pred_valid = 0; pred_pc = 0; pred_ctr = 0; pred_target = 0;
    res_valid = 0; res_taken = 0; res_target = 0;
    #12;
    check("rst inflight",   32'(inflight), 0);
    check("rst pred_ready", 32'(pred_ready), 1);
    check("rst upd_valid",  32'(upd_valid), 0);
    check("rst branch_cnt", 32'(branch_cnt), 0);
    rst_n = 1'b1;
    idle();

    // Correct taken resolve on strongly-taken entry.
    step(1, 32'h14, 2'b11, 32'h40, 0, 0, 0);
    step(0, 0, 0, 0, 1, 1, 32'h40);
    check("t1 upd_valid",  32'(upd_valid), 1);
    check("t1 upd_idx",    32'(upd_idx), 32'h4);
    check("t1 upd_ctr",    32'(upd_ctr), 3);
    check("t1 flush",      32'(flush), 0);
    check("t1 branch_cnt", 32'(branch_cnt), 1);
    check("t1 inflight",   32'(inflight), 0);

    // Predicted taken, actually not taken.
    step(1, 32'h08, 2'b10, 32'h100, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0, 0);
    check("t2 upd_ctr",     32'(upd_ctr), 1);
    check("t2 flush",       32'(flush), 1);
    check("t2 redirect",    redirect_pc, 32'h0C);
    check("t2 mispred_cnt", 32'(mispred_cnt), 1);
    idle();
    check("t2 flush drop",  32'(flush), 0);

    // Taken as predicted, but wrong target.
    step(1, 32'h20, 2'b11, 32'h80, 0, 0, 0);
    step(0, 0, 0, 0, 1, 1, 32'h90);
    check("t3 flush",    32'(flush), 1);
    check("t3 redirect", redirect_pc, 32'h90);
    check("t3 upd_ctr",  32'(upd_ctr), 3);

    // Simultaneous correct pop + push when not full, then saturation at 00.
    step(1, 32'h50, 2'b10, 32'h60, 0, 0, 0);
    step(1, 32'h54, 2'b00, 32'h0,  0, 0, 0);
    step(1, 32'h58, 2'b00, 32'h0,  1, 1, 32'h60);
    check("t4 inflight same", 32'(inflight), 2);
    check("t4 upd_ctr",       32'(upd_ctr), 3);
    step(0, 0, 0, 0, 1, 0, 0);
    check("t4 sat0 a", 32'(upd_ctr), 0);
    step(0, 0, 0, 0, 1, 0, 0);
    check("t4 sat0 b", 32'(upd_ctr), 0);
    check("t4 idx",    32'(upd_idx), 32'h8);

    // Fill, overflow push, full pop+push (no bypass), mispredict squash.
    for (int i = 0; i < 4; i++) step(1, 32'h30 + 32'(4 * i), 2'b01, 0, 0, 0, 0);
    check("t5 inflight full", 32'(inflight), 4);
    check("t5 ready full",    32'(pred_ready), 0);
    step(1, 32'h99, 2'b01, 0, 0, 0, 0);
    check("t5 5th ignored",   32'(inflight), 4);
    step(1, 32'h9C, 2'b01, 0, 1, 0, 0);
    check("t5 no bypass",     32'(inflight), 3);
    step(1, 32'hA0, 2'b01, 0, 1, 1, 32'h200);
    check("t5 squash infl",   32'(inflight), 0);
    check("t5 squash ready",  32'(pred_ready), 1);
    check("t5 squash redir",  redirect_pc, 32'h200);
    check("t5 upd_idx",       32'(upd_idx), 32'h4);
    idle();
    check("t5 push dropped",  32'(inflight), 0);

    // Resolve with empty FIFO.
    step(0, 0, 0, 0, 1, 1, 0);
    check("t6 upd_valid", 32'(upd_valid), 0);
    check("t6 flush",     32'(flush), 0);
    check("t6 err",       32'(err_underflow), 1);
    check("t6 branch",    32'(branch_cnt), 8);
    idle();
    check("t6 err held",  32'(err_underflow), 1);

    // Asynchronous reset mid-cycle while pulses are high.
    step(1, 32'h14, 2'b11, 32'h40, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0, 0);
    #2 rst_n = 1'b0;
    #1;
    check("ar flush",    32'(flush), 0);
    check("ar upd",      32'(upd_valid), 0);
    check("ar redirect", redirect_pc, 0);
    check("ar err",      32'(err_underflow), 0);
    check("ar branch",   32'(branch_cnt), 0);
    check("ar mispred",  32'(mispred_cnt), 0);
    #2 rst_n = 1'b1;
    idle();

    // Saturate branch_cnt: one correct resolve per cycle with a steady push.
    step(1, 32'h10, 2'b11, 32'h40, 0, 0, 0);
    for (int i = 0; i < 65538; i++) step(1, 32'h10, 2'b11, 32'h40, 1, 1, 32'h40);
    check("sat branch_cnt", 32'(branch_cnt), 32'hFFFF);
    check("sat mispred",    32'(mispred_cnt), 0);
    idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
Resolution end of the 2-bit-counter branch prediction path. Holds each fetched branch's prediction in an in-order FIFO until execute resolves it. Compares the actual outcome against the prediction and drives the BHT counter write-back to the predictor. On a mispredict, pulses a flush and redirect toward fetch.

Parameters:
N, 32, PC and target width
DEPTH, 4, max in-flight branches (power of 2, >=2)
IDX, 4, BHT index width; index = pc[IDX-1:0], same mapping as the predictor
CW (localparam), $clog2(DEPTH)+1, occupancy width

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
pred_valid  in  1  fetch presents a predicted branch
pred_pc  in  N  branch PC
pred_ctr  in  2  BHT counter value read at fetch
pred_target  in  N  predicted taken target
pred_ready  out  1  FIFO not full
res_valid  in  1  execute resolves the oldest in-flight branch
res_taken  in  1  actual direction
res_target  in  N  actual taken target
flush  out  1  one-cycle mispredict pulse
redirect_pc  out  N  correct next PC, valid while flush=1
upd_valid  out  1  one-cycle BHT write strobe
upd_idx  out  IDX  BHT entry to write
upd_ctr  out  2  new counter value
inflight  out  CW  current FIFO occupancy
branch_cnt  out  16  resolved branches, saturating
mispred_cnt  out  16  mispredicts, saturating
err_underflow  out  1  sticky: resolve seen while FIFO empty

Behaviour:
- Reset (async, rst_n=0): FIFO pointers, inflight, flush, redirect_pc, upd_valid, upd_idx, upd_ctr, both counters and err_underflow all 0. Reset mid-operation discards all entries immediately.
- Predicted direction is not a port. It is pred_ctr[1] (taken when the counter is 2'b10 or 2'b11).
- pred_ready = (inflight < DEPTH), combinational from registered occupancy.
- Push: pred_valid && pred_ready stores {pc, ctr, target} at the tail. A push while full is ignored, and no state changes.
- Resolve: res_valid && inflight!=0 pops the head. All outputs below are registered and appear the cycle after the resolve edge, for exactly 1 cycle.
  - upd_valid=1 and upd_idx=head.pc[IDX-1:0].
  - upd_ctr = sat_inc(head.ctr) if res_taken, else sat_dec(head.ctr). The counter saturates at 2'b11 and at 2'b00.
  - mispredict = (res_taken != head.ctr[1]) || (res_taken && head.ctr[1] && res_target != head.target).
  - branch_cnt increments, saturating at 16'hFFFF.
  - If mispredict: flush=1, redirect_pc = res_taken ? res_target : head.pc+4 (mod 2^N), and mispred_cnt increments, saturating.
- Mispredict squash: on the mispredict resolve edge, all younger entries are discarded and inflight becomes 0. A push in that same cycle is wrong-path and is dropped.
- Correct resolve plus simultaneous push: pop and push both occur, and inflight is unchanged. A push is accepted even when full, provided a correct pop happens the same cycle.
  - In that case pred_ready stays at its registered value (0 when full), so fetch sees not-ready and the accepted push is only a same-cycle bypass.
  - Decided: no bypass. A push requires pred_ready=1, regardless of any pop.
- Resolve while empty: no pop, upd_valid=0, flush=0, counters unchanged, err_underflow set to 1 until reset.
- Pointers wrap modulo DEPTH. inflight ranges 0..DEPTH.
- flush, redirect_pc and upd_* return to 0 on the cycle after a pulse unless another resolve occurred.

Test Plan:
- Reset, then push pc=0x14 with ctr=2'b11 and target=0x40; resolve taken with target 0x40 -> next cycle upd_valid=1, upd_idx=4'h4, upd_ctr=2'b11, flush=0, branch_cnt=1, inflight=0.
- Push pc=0x08 with ctr=2'b10; resolve not-taken -> upd_ctr=2'b01, flush=1, redirect_pc=0x0C, mispred_cnt=1.
- Push pc=0x20 with ctr=2'b11 and target=0x80; resolve taken with target 0x90 -> flush=1, redirect_pc=0x90, upd_ctr=2'b11.
- Push 4 entries -> pred_ready=0 and inflight=4; a 5th push is ignored. A mispredict on the head -> inflight=0, pred_ready=1, and a push in the same cycle is not stored.
- Resolve with FIFO empty -> no upd_valid, no flush, err_underflow=1 and held; assert rst_n=0 asynchronously mid-clock -> all outputs 0 immediately.
- Back-to-back correct resolves on ctr=2'b00 entries, not-taken -> upd_ctr stays 2'b00 (saturation). Force branch_cnt to 16'hFFFF via 65535 resolves -> it holds at FFFF.
